// File: rtl/thread_regfile_if.sv
// Core-side bus of a single thread's register file.
// Carries the thread-active flag, block index, core FSM state, decoded
// instruction fields, the ALU/LSU write-back sources and the registered
// rs/rt operands.
//   master : core / decoder / ALU / LSU side (drives requests, reads operands)
//   slave  : register file side (consumes requests, drives rs/rt)
interface thread_regfile_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic                 enable;
   logic [7:0]           block_id;
   logic [2:0]           core_state;
   logic [3:0]           decoded_rd_address;
   logic [3:0]           decoded_rs_address;
   logic [3:0]           decoded_rt_address;
   logic                 decoded_reg_write_enable;
   logic [1:0]           decoded_reg_input_mux;
   logic [7:0]           decoded_immediate;
   logic [DATA_BITS-1:0] alu_out;
   logic [DATA_BITS-1:0] lsu_out;
   logic [DATA_BITS-1:0] rs;
   logic [DATA_BITS-1:0] rt;

   modport master (
      output enable, block_id, core_state,
      output decoded_rd_address, decoded_rs_address, decoded_rt_address,
      output decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
      output alu_out, lsu_out,
      input  rs, rt
   );

   modport slave (
      input  enable, block_id, core_state,
      input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
      input  decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
      input  alu_out, lsu_out,
      output rs, rt
   );
endinterface

// File: rtl/thread_regfile.sv
// Per-thread register file for the SIMT compute core.
// 16 registers of DATA_BITS: R0-R12 general purpose, R13 mirrors block_id
// (one-cycle lag), R14 = THREADS_PER_BLOCK, R15 = THREAD_ID (read-only).
// Ports:
//   clk       : core clock, all updates on rising edge
//   reset     : synchronous active-high reset
//   bus       : thread_regfile_if.slave (enable, block_id, core_state,
//               decoded fields, alu_out, lsu_out in; rs, rt out)
//   write_err : sticky illegal-write flag, only when
//               THREAD_REGFILE_WRITE_ERR_EN is defined
module thread_regfile #(
   parameter int unsigned THREADS_PER_BLOCK = 4,
   parameter int unsigned THREAD_ID         = 0,
   parameter int unsigned DATA_BITS         = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   thread_regfile_if.slave      bus
`ifdef THREAD_REGFILE_WRITE_ERR_EN
   ,
   output logic                 write_err
`endif
);

   localparam int unsigned NUM_GP   = 13;
   localparam int unsigned NUM_REGS = 16;

   localparam logic [2:0] ST_REQUEST = 3'b010;
   localparam logic [2:0] ST_UPDATE  = 3'b110;

   localparam logic [1:0] MUX_ALU   = 2'b00;
   localparam logic [1:0] MUX_MEM   = 2'b01;
   localparam logic [1:0] MUX_CONST = 2'b10;

   localparam logic [DATA_BITS-1:0] BLOCK_DIM = DATA_BITS'(THREADS_PER_BLOCK);
   localparam logic [DATA_BITS-1:0] THREAD_IX = DATA_BITS'(THREAD_ID);

   logic [DATA_BITS-1:0] gp [NUM_GP];
   logic [DATA_BITS-1:0] block_idx;
   logic [DATA_BITS-1:0] view [NUM_REGS];
   logic [DATA_BITS-1:0] wdata;
   logic                 is_request;
   logic                 is_update_we;
   logic                 wr_legal;

   // Architectural view of all 16 registers for the operand read ports.
   always_comb begin
      for (int i = 0; i < int'(NUM_GP); i++) begin
         view[i] = gp[i];
      end
      view[13] = block_idx;
      view[14] = BLOCK_DIM;
      view[15] = THREAD_IX;
   end

   // Write-back source select; reserved mux code is flagged as illegal below.
   always_comb begin
      wdata = '0;
      case (bus.decoded_reg_input_mux)
         MUX_ALU:   wdata = bus.alu_out;
         MUX_MEM:   wdata = bus.lsu_out;
         MUX_CONST: wdata = DATA_BITS'(bus.decoded_immediate);
         default:   wdata = '0;
      endcase
   end

   always_comb begin
      is_request   = (bus.core_state == ST_REQUEST);
      is_update_we = (bus.core_state == ST_UPDATE) && bus.decoded_reg_write_enable;
      wr_legal     = is_update_we
                     && (bus.decoded_rd_address < 4'(NUM_GP))
                     && (bus.decoded_reg_input_mux != 2'b11);
   end

   // Register state and operand latches; enable low freezes everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_GP); i++) begin
            gp[i] <= '0;
         end
         block_idx <= '0;
         bus.rs    <= '0;
         bus.rt    <= '0;
      end else if (bus.enable) begin
         block_idx <= DATA_BITS'(bus.block_id);
         if (is_request) begin
            bus.rs <= view[bus.decoded_rs_address];
            bus.rt <= view[bus.decoded_rt_address];
         end
         for (int i = 0; i < int'(NUM_GP); i++) begin
            if (wr_legal && (bus.decoded_rd_address == 4'(i))) begin
               gp[i] <= wdata;
            end
         end
      end
   end

`ifdef THREAD_REGFILE_WRITE_ERR_EN
   // Sticky flag for writes aimed at read-only registers or the reserved source.
   always_ff @(posedge clk) begin
      if (reset) begin
         write_err <= 1'b0;
      end else if (bus.enable && is_update_we
                   && ((bus.decoded_rd_address >= 4'(NUM_GP))
                       || (bus.decoded_reg_input_mux == 2'b11))) begin
         write_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_thread_regfile.sv
// Self-checking bench for thread_regfile: directed steps followed by
// randomized cycles, compared against a behavioural register-file model.
module tb_thread_regfile;

   localparam int unsigned TPB = 4;
   localparam int unsigned TID = 2;

   localparam logic [2:0] REQ = 3'b010;
   localparam logic [2:0] UPD = 3'b110;
   localparam logic [2:0] IDL = 3'b000;

   logic clk = 1'b0;
   logic reset;
`ifdef THREAD_REGFILE_WRITE_ERR_EN
   logic write_err;
`endif

   thread_regfile_if #(.DATA_BITS(8)) bus ();

   thread_regfile #(
      .THREADS_PER_BLOCK(TPB),
      .THREAD_ID(TID),
      .DATA_BITS(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
`ifdef THREAD_REGFILE_WRITE_ERR_EN
      ,
      .write_err(write_err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: 16 architectural registers plus operand latches.
   logic [7:0] m_reg [16];
   logic [7:0] m_rs, m_rt;
   logic       m_err;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
      m_reg[14] = 8'(TPB);
      m_reg[15] = 8'(TID);
      m_rs = 8'h00;
      m_rt = 8'h00;
      m_err = 1'b0;
   endtask

   // Applies one clock of architectural rules using the pre-edge inputs.
   task automatic model_step();
      logic [7:0] src;
      if (reset) begin
         model_reset();
      end else if (bus.enable) begin
         if (bus.core_state == REQ) begin
            m_rs = m_reg[bus.decoded_rs_address];
            m_rt = m_reg[bus.decoded_rt_address];
         end
         if (bus.core_state == UPD && bus.decoded_reg_write_enable) begin
            case (bus.decoded_reg_input_mux)
               2'b00:   src = bus.alu_out;
               2'b01:   src = bus.lsu_out;
               default: src = bus.decoded_immediate;
            endcase
            if (bus.decoded_rd_address <= 4'd12 && bus.decoded_reg_input_mux != 2'b11)
               m_reg[bus.decoded_rd_address] = src;
            else
               m_err = 1'b1;
         end
         m_reg[13] = bus.block_id;
      end
   endtask

   task automatic check_outputs(input string tag);
      checks++;
      assert (bus.rs === m_rs) else begin
         errors++;
         $error("FAIL %s.rs observed=%h expected=%h", tag, bus.rs, m_rs);
      end
      checks++;
      assert (bus.rt === m_rt) else begin
         errors++;
         $error("FAIL %s.rt observed=%h expected=%h", tag, bus.rt, m_rt);
      end
`ifdef THREAD_REGFILE_WRITE_ERR_EN
      checks++;
      assert (write_err === m_err) else begin
         errors++;
         $error("FAIL %s.write_err observed=%b expected=%b", tag, write_err, m_err);
      end
`endif
   endtask

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_outputs(tag);
   endtask

   task automatic idle_inputs();
      reset = 1'b0;
      bus.core_state = IDL;
      bus.decoded_reg_write_enable = 1'b0;
      bus.decoded_rd_address = 4'd0;
      bus.decoded_rs_address = 4'd0;
      bus.decoded_rt_address = 4'd0;
      bus.decoded_reg_input_mux = 2'b00;
      bus.decoded_immediate = 8'h00;
      bus.alu_out = 8'h00;
      bus.lsu_out = 8'h00;
   endtask

   task automatic req(input logic [3:0] a, input logic [3:0] b, input string tag);
      idle_inputs();
      bus.core_state = REQ;
      bus.decoded_rs_address = a;
      bus.decoded_rt_address = b;
      cycle(tag);
   endtask

   task automatic upd(input logic [3:0] rd, input logic [1:0] mux, input logic we,
                      input logic [7:0] imm, input logic [7:0] alu, input logic [7:0] lsu,
                      input string tag);
      idle_inputs();
      bus.core_state = UPD;
      bus.decoded_rd_address = rd;
      bus.decoded_reg_input_mux = mux;
      bus.decoded_reg_write_enable = we;
      bus.decoded_immediate = imm;
      bus.alu_out = alu;
      bus.lsu_out = lsu;
      cycle(tag);
   endtask

   initial begin
      model_reset();
      idle_inputs();
      bus.enable = 1'b1;
      bus.block_id = 8'd5;
      reset = 1'b1;
      cycle("reset0");
      reset = 1'b1;
      cycle("reset1");
      check_val("reset_rs", bus.rs, 8'h00);
      check_val("reset_rt", bus.rt, 8'h00);

      // Special registers.
      req(4'd14, 4'd15, "req_dim_tid");
      check_val("blockdim", bus.rs, 8'd4);
      check_val("threadidx", bus.rt, 8'd2);
      req(4'd13, 4'd13, "req_bid");
      check_val("blockidx", bus.rs, 8'd5);

      // Constant and ALU write-back.
      upd(4'd3, 2'b10, 1'b1, 8'h7F, 8'h00, 8'h00, "upd_const");
      req(4'd3, 4'd0, "req_r3");
      check_val("r3_const", bus.rs, 8'h7F);
      check_val("r0_zero", bus.rt, 8'h00);
      upd(4'd3, 2'b00, 1'b1, 8'h00, 8'hA5, 8'h00, "upd_alu");
      req(4'd3, 4'd0, "req_r3b");
      check_val("r3_alu", bus.rs, 8'hA5);

      // Illegal write to R15.
      upd(4'd15, 2'b01, 1'b1, 8'h00, 8'h00, 8'hEE, "upd_r15");
      upd(4'd1, 2'b11, 1'b1, 8'h99, 8'h99, 8'h99, "upd_resv");
      req(4'd15, 4'd1, "req_r15");
      check_val("r15_ro", bus.rs, 8'd2);
      check_val("r1_resv", bus.rt, 8'h00);

      // Frozen thread.
      bus.enable = 1'b0;
      upd(4'd1, 2'b10, 1'b1, 8'h11, 8'h00, 8'h00, "dis_upd");
      bus.block_id = 8'd9;
      req(4'd1, 4'd13, "dis_req");
      cycle("dis_idle");
      bus.enable = 1'b1;
      req(4'd1, 4'd13, "en_req");
      check_val("r1_frozen", bus.rs, 8'h00);
      check_val("r13_frozen", bus.rt, 8'd5);
      req(4'd13, 4'd13, "en_req2");
      check_val("r13_mirror", bus.rs, 8'd9);

      // Same-address read and write-enable low.
      upd(4'd4, 2'b01, 1'b1, 8'h00, 8'h00, 8'h33, "upd_r4");
      req(4'd4, 4'd4, "req_r4");
      check_val("r4_rs", bus.rs, 8'h33);
      check_val("r4_rt", bus.rt, 8'h33);
      upd(4'd4, 2'b10, 1'b0, 8'h00, 8'h00, 8'h00, "upd_we0");
      req(4'd4, 4'd3, "req_r4b");
      check_val("r4_hold", bus.rs, 8'h33);

      // Reset colliding with a write.
      upd(4'd2, 2'b10, 1'b1, 8'h55, 8'h00, 8'h00, "upd_r2");
      idle_inputs();
      bus.core_state = UPD;
      bus.decoded_rd_address = 4'd2;
      bus.decoded_reg_input_mux = 2'b10;
      bus.decoded_reg_write_enable = 1'b1;
      bus.decoded_immediate = 8'hAA;
      reset = 1'b1;
      cycle("reset_upd");
      check_val("rst_rs", bus.rs, 8'h00);
      req(4'd2, 4'd14, "req_r2");
      check_val("r2_reset", bus.rs, 8'h00);
      check_val("r14_reset", bus.rt, 8'd4);
      req(4'd15, 4'd13, "req_r15b");
      check_val("r15_reset", bus.rs, 8'd2);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         idle_inputs();
         reset = ($urandom_range(0, 59) == 0);
         bus.enable = ($urandom_range(0, 7) != 0);
         bus.block_id = 8'($urandom);
         case ($urandom_range(0, 4))
            0, 1:    bus.core_state = REQ;
            2, 3:    bus.core_state = UPD;
            default: bus.core_state = 3'($urandom);
         endcase
         bus.decoded_rd_address = 4'($urandom);
         bus.decoded_rs_address = 4'($urandom);
         bus.decoded_rt_address = 4'($urandom);
         bus.decoded_reg_write_enable = ($urandom_range(0, 3) != 0);
         bus.decoded_reg_input_mux = 2'($urandom);
         bus.decoded_immediate = 8'($urandom);
         bus.alu_out = 8'($urandom);
         bus.lsu_out = 8'($urandom);
         cycle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/thread_regfile.md
Name: thread_regfile

Overview:
- Per-thread register file for the SIMT compute core; one instance per thread, alongside that thread's ALU and LSU.
- Supplies the ALU's rs/rt operands in the REQUEST state.
- Writes back ALU results, LSU load data or decoded immediates in the UPDATE state.
- Holds 16 x 8-bit registers: R0–R12 general purpose; R13 = %blockIdx, R14 = %blockDim, R15 = %threadIdx, all three read-only.

Parameters:
- THREADS_PER_BLOCK, 4, value held in R14 (%blockDim); must be 1..255.
- THREAD_ID, 0, value held in R15 (%threadIdx); must be < THREADS_PER_BLOCK.
- DATA_BITS, 8, register and operand width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  thread active in current block; low freezes all state.
- block_id  input  8  current block index, mirrored into R13.
- core_state  input  3  core FSM state: REQUEST=3'b010, UPDATE=3'b110; all other encodings are no-ops here.
- decoded_rd_address  input  4  destination register index.
- decoded_rs_address  input  4  first source register index.
- decoded_rt_address  input  4  second source register index.
- decoded_reg_write_enable  input  1  instruction writes rd.
- decoded_reg_input_mux  input  2  write source select: 00 = ALU, 01 = MEMORY, 10 = CONSTANT, 11 = reserved.
- decoded_immediate  input  8  constant for CONST instruction.
- alu_out  input  8  ALU result.
- lsu_out  input  8  LSU load data.
- rs  output  8  registered operand 1 to ALU/LSU.
- rt  output  8  registered operand 2 to ALU/LSU.
- write_err  output  1  sticky illegal-write flag; present only with THREAD_REGFILE_WRITE_ERR_EN.

Behaviour:
- Reset (sync, highest priority, independent of enable):
  - R0–R12 = 0, R13 = 0, R14 = THREADS_PER_BLOCK, R15 = THREAD_ID.
  - rs = 0, rt = 0.
  - Reset mid-instruction discards any pending read or write.
- enable low: no register, rs or rt changes, including R13.
- enable high, every cycle: R13 <= block_id.
  - R13 therefore lags block_id by one cycle.
  - A same-cycle read of R13 returns the pre-edge value.
- core_state == REQUEST:
  - rs <= R[decoded_rs_address], rt <= R[decoded_rt_address].
  - Single-cycle latency; operands are valid from the first cycle after REQUEST.
  - rs_address == rt_address is legal; both outputs get the same value.
- core_state == UPDATE and decoded_reg_write_enable == 1 and decoded_rd_address <= 12:
  - mux 00: R[rd] <= alu_out.
  - mux 01: R[rd] <= lsu_out.
  - mux 10: R[rd] <= decoded_immediate.
  - mux 11: no write.
- Write to rd 13..15: silently dropped; the R13 mirror from block_id still occurs; R14/R15 never change after reset.
- rs/rt are not updated in UPDATE or any other non-REQUEST state; they hold until the next REQUEST.
- No read/write hazard: REQUEST and UPDATE are mutually exclusive states, so no bypass path exists.
- Values wrap modulo 2^DATA_BITS; no saturation.

Optional Feature:
- Macro THREAD_REGFILE_WRITE_ERR_EN.
- Defined:
  - write_err port exists, resets to 0.
  - Set to 1 on any enabled UPDATE cycle with decoded_reg_write_enable == 1 and (decoded_rd_address >= 13 or decoded_reg_input_mux == 11).
  - Remains set until reset; the write itself is still dropped.
- Undefined: port and logic absent; illegal writes silently dropped.

Test Plan:
- Reset, THREADS_PER_BLOCK=4, THREAD_ID=2, block_id=5, enable=1; REQUEST with rs_addr=14, rt_addr=15 -> rs=4, rt=2; then REQUEST rs_addr=13 -> rs=5.
- UPDATE rd=3, mux=10, imm=0x7F, we=1; then REQUEST rs=3, rt=0 -> rs=0x7F, rt=0x00; repeat with mux=00, alu_out=0xA5 -> rs=0xA5.
- UPDATE rd=15, mux=01, lsu_out=0xEE, we=1 -> later REQUEST rs=15 returns THREAD_ID; with macro, write_err=1 from next cycle and stays 1 until reset.
- enable=0, UPDATE rd=1 imm=0x11 and block_id change -> R1 and R13 unchanged on next enabled REQUEST; rs/rt hold their prior values throughout.
- REQUEST with rs_addr=rt_addr=4 (R4=0x33) -> rs=rt=0x33; UPDATE with we=0, rd=4, imm=0x00 -> R4 remains 0x33.
- Write R2=0x55, assert reset in the same cycle as an UPDATE to R2 -> R2=0, rs=rt=0, write_err=0, R14/R15 at parameter values.
